mole_hit_scorer: RTL and testbench



---
 rtl/whac_pkg.sv | 15 +
 rtl/mole_hit_scorer_sync_edge_detect.sv | 24 ++
 rtl/mole_hit_scorer.sv | 103 ++++++++++
 tb/tb_mole_hit_scorer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/whac_pkg.sv
// whac_pkg: shared game constants, state/vector types and popcount helper.
package whac_pkg;
  localparam int N_HOLES   = 18;
  localparam int ROUNDS    = 30;
  localparam int SCORE_MAX = 999;
  localparam int PC_W      = $clog2(N_HOLES + 1);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;
  typedef logic [N_HOLES-1:0] hole_vec_t;
  function automatic logic [PC_W-1:0] popcount(hole_vec_t v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_HOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/mole_hit_scorer_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser plus prev flop, reporting toggles and rising edges.
module sync_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] toggle_o,
  output logic [WIDTH-1:0] rise_o
);
  logic [WIDTH-1:0] s1_q, s2_q, prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  assign toggle_o = s2_q ^ prev_q;
  assign rise_o   = s2_q & ~prev_q;
endmodule

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: latches mole waves, scores switch whacks and runs the IDLE/PLAY/OVER game.
module mole_hit_scorer
  import whac_pkg::*;
#(
  parameter int ROUNDS    = whac_pkg::ROUNDS,
  parameter int SCORE_W   = 10,
  parameter int SCORE_MAX = whac_pkg::SCORE_MAX,
  parameter int MISS_W    = 8,
  localparam int RC_W     = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mole_clk,
  input  hole_vec_t          mole_positions,
  input  hole_vec_t          switches,
  output hole_vec_t          active_moles,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic [RC_W-1:0]    round_count,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               playing,
  output logic               game_over
);
  game_state_t        state_q, state_d;
  hole_vec_t          active_q, active_d, whack, hits, empty, sw_rise;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic [RC_W-1:0]    round_q, round_d, round_inc;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic [0:0]         mc_toggle, mc_rise;
  logic [SCORE_W:0]   score_sum;
  logic [MISS_W:0]    miss_sum;
  logic               last_wave, unused_sig;
  sync_edge_detect #(.WIDTH(N_HOLES)) u_sw_sync (
    .clk(clk), .rst(rst), .d_i(switches), .toggle_o(whack), .rise_o(sw_rise)
  );
  sync_edge_detect #(.WIDTH(1)) u_mc_sync (
    .clk(clk), .rst(rst), .d_i(mole_clk), .toggle_o(mc_toggle), .rise_o(mc_rise)
  );
  assign unused_sig = ^{sw_rise, mc_toggle};
  assign hits       = whack & active_q;
  assign empty      = whack & ~active_q;
  assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(popcount(hits));
  assign miss_sum   = {1'b0, misses_q} + (MISS_W+1)'(popcount(empty));
  assign round_inc  = round_q + RC_W'(1);
  assign last_wave  = round_inc == RC_W'(ROUNDS);
  // Whacks are scored against the pre-wave moles; a wave then overwrites the hit-clear.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    score_d  = score_q;
    misses_d = misses_q;
    round_d  = round_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (state_q == PLAY) begin
      score_d  = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
      misses_d = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
      hit_d    = |hits;
      miss_d   = |empty;
      active_d = active_q & ~hits;
      if (mc_rise[0]) begin
        round_d  = round_inc;
        active_d = last_wave ? '0 : mole_positions;
        state_d  = last_wave ? OVER : PLAY;
      end
    end else if (start) begin
      state_d  = PLAY;
      active_d = '0;
      score_d  = '0;
      misses_d = '0;
      round_d  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      score_q  <= '0;
      misses_q <= '0;
      round_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      round_q  <= round_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  assign active_moles = active_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign round_count  = round_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign playing      = state_q == PLAY;
  assign game_over    = state_q == OVER;
endmodule

// File: tb/tb_mole_hit_scorer.sv
// tb_mole_hit_scorer: directed plus randomized game traffic checked against a rule-level model.
module tb_mole_hit_scorer;
  localparam int RND  = 3;
  localparam int SMAX = 20;
  localparam int MW   = 4;
  localparam int MSAT = 15;
  logic        clk, rst, start, mole_clk, hit_pulse, miss_pulse, playing, game_over;
  logic [17:0] mole_positions, switches, active_moles;
  logic [9:0]  score;
  logic [MW-1:0] misses;
  logic [1:0]  round_count;
  int n_checks = 0, n_errors = 0;
  int m_state, m_score, m_miss, m_round;
  logic [17:0] m_active;
  logic m_hp, m_mp;
  logic [17:0] sw_h[4];
  logic mc_h[4];
  mole_hit_scorer #(.ROUNDS(RND), .SCORE_W(10), .SCORE_MAX(SMAX), .MISS_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .mole_clk(mole_clk),
    .mole_positions(mole_positions), .switches(switches), .active_moles(active_moles),
    .score(score), .misses(misses), .round_count(round_count), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .playing(playing), .game_over(game_over)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference: a whack/wave seen by the DUT at edge k is the input change between samples k-3 and k-2.
  task automatic model();
    logic [17:0] w, h, e;
    logic wv;
    if (rst) begin
      m_state = 0; m_active = 0; m_score = 0; m_miss = 0; m_round = 0; m_hp = 0; m_mp = 0;
      for (int i = 0; i < 4; i++) begin sw_h[i] = 0; mc_h[i] = 0; end
      return;
    end
    for (int i = 3; i > 0; i--) begin sw_h[i] = sw_h[i-1]; mc_h[i] = mc_h[i-1]; end
    sw_h[0] = switches;
    mc_h[0] = mole_clk;
    w  = sw_h[2] ^ sw_h[3];
    wv = mc_h[2] & !mc_h[3];
    m_hp = 0;
    m_mp = 0;
    if (m_state == 1) begin
      h = w & m_active;
      e = w & ~m_active;
      m_score = m_score + $countones(h);
      if (m_score > SMAX) m_score = SMAX;
      m_miss = m_miss + $countones(e);
      if (m_miss > MSAT) m_miss = MSAT;
      m_hp = h != 0;
      m_mp = e != 0;
      m_active = m_active & ~h;
      if (wv) begin
        m_round++;
        if (m_round == RND) begin m_active = 0; m_state = 2; end
        else m_active = mole_positions;
      end
    end else if (start) begin
      m_state = 1; m_active = 0; m_score = 0; m_miss = 0; m_round = 0;
    end
  endtask
  task automatic compare_all();
    check("active", 32'(active_moles), 32'(m_active));
    check("score", 32'(score), 32'(m_score));
    check("misses", 32'(misses), 32'(m_miss));
    check("round", 32'(round_count), 32'(m_round));
    check("hit_pulse", 32'(hit_pulse), 32'(m_hp));
    check("miss_pulse", 32'(miss_pulse), 32'(m_mp));
    check("playing", 32'(playing), 32'(m_state == 1));
    check("game_over", 32'(game_over), 32'(m_state == 2));
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
    compare_all();
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  initial begin
    int cnt;
    rst = 1; start = 0; mole_clk = 0; mole_positions = 0; switches = 0;
    run(2);
    rst = 0;
    tick();
    check("idle_playing", 32'(playing), 0);
    pulse_start();
    check("start_play", 32'(playing), 1);
    check("start_score", 32'(score), 0);
    check("start_active", 32'(active_moles), 0);
    mole_positions = 18'h00005; mole_clk = 1;
    run(3);
    check("wave1_active", 32'(active_moles), 32'h5);
    check("wave1_round", 32'(round_count), 1);
    run(2);
    mole_clk = 0;
    switches ^= 18'h1;
    run(3);
    check("hit_score", 32'(score), 1);
    check("hit_active", 32'(active_moles), 32'h4);
    check("hit_pulse_on", 32'(hit_pulse), 1);
    tick();
    check("hit_pulse_off", 32'(hit_pulse), 0);
    switches ^= 18'h6;
    run(3);
    check("mix_score", 32'(score), 2);
    check("mix_misses", 32'(misses), 1);
    check("mix_active", 32'(active_moles), 0);
    check("mix_pulses", 32'({hit_pulse, miss_pulse}), 3);
    mole_positions = 18'h00010; mole_clk = 1; switches ^= 18'h10;
    run(3);
    check("same_misses", 32'(misses), 2);
    check("same_score", 32'(score), 2);
    check("same_active", 32'(active_moles), 32'h10);
    run(3);
    mole_clk = 0;
    run(4);
    mole_positions = 18'h3ffff; mole_clk = 1;
    run(3);
    check("over_flag", 32'(game_over), 1);
    check("over_active", 32'(active_moles), 0);
    check("over_round", 32'(round_count), RND);
    mole_clk = 0; switches ^= 18'h3;
    run(5);
    check("over_frozen", 32'({score, misses}), 32'({10'd2, 4'd2}));
    pulse_start();
    check("restart", 32'({playing, score, misses, round_count}), 32'({1'b1, 16'd0}));
    mole_positions = 18'h3ffff; mole_clk = 1;
    run(4);
    mole_clk = 0; switches ^= 18'h3ffff;
    run(3);
    check("all_hit_score", 32'(score), 18);
    run(2);
    mole_clk = 1;
    run(4);
    mole_clk = 0; switches ^= 18'h3ffff;
    run(3);
    check("sat_score", 32'(score), SMAX);
    check("sat_hit_pulse", 32'(hit_pulse), 1);
    switches ^= 18'h3ffff;
    run(3);
    check("sat_misses", 32'(misses), MSAT);
    rst = 1;
    #1;
    check("async_rst", 32'({playing, game_over, score, misses, round_count}), 0);
    check("async_rst_active", 32'(active_moles), 0);
    tick();
    rst = 0;
    cnt = 5;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) switches ^= 18'(1) << $urandom_range(0, 17);
      if ($urandom_range(0, 7) == 0) switches ^= 18'($urandom);
      if (--cnt == 0) begin
        mole_clk = ~mole_clk;
        if (mole_clk) mole_positions = 18'($urandom | $urandom);
        cnt = $urandom_range(4, 8);
      end
      start = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 1500) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
